sc_cpu_core: RTL and testbench

- Multi-cycle 8-bit datapath that sits directly downstream of the instruction ROM/tester.
- Drives the ROM `address` input and consumes the 8-bit `instruction` it returns combinationally in the same cycle.
- Executes a 4-opcode ISA against a 4x8 register file and a 32x8 data memory.
- Stops on the halt encoding and exposes write-back and debug ports for benches.

---
 rtl/sc_cpu_core_if.sv | 35 +++
 rtl/sc_cpu_core.sv | 118 +++++++++++
 tb/tb_sc_cpu_core.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sc_cpu_core_if.sv
// rtl/sc_cpu_core_if.sv - ROM, write-back and debug signal bundle for sc_cpu_core
interface sc_cpu_core_if;
  logic [7:0] instruction;
  logic [7:0] address;
  logic       halted;
  logic       rw_en;
  logic [7:0] rw_data;
  logic [1:0] rw_idx;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  // core side
  modport master (
    input  instruction,
    input  dbg_sel,
    output address,
    output halted,
    output rw_en,
    output rw_data,
    output rw_idx,
    output dbg_data
  );

  // ROM / bench side
  modport slave (
    output instruction,
    output dbg_sel,
    input  address,
    input  halted,
    input  rw_en,
    input  rw_data,
    input  rw_idx,
    input  dbg_data
  );
endinterface

// File: rtl/sc_cpu_core.sv
// rtl/sc_cpu_core.sv - multi-cycle 8-bit core with 4x8 register file and data memory
module sc_cpu_core #(
  parameter int         DMEM_DEPTH = 32,
  parameter logic [7:0] HALT_WORD  = 8'b11000011
) (
  input  logic          clk,
  input  logic          clear,
  sc_cpu_core_if.master bus
);
  localparam int AW = $clog2(DMEM_DEPTH);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [7:0] regs [4];
  logic [7:0] dmem [DMEM_DEPTH];

  logic       halted_q;
  logic       rw_en_q;
  logic [7:0] rw_data_q;
  logic [1:0] rw_idx_q;

  logic [7:0]    rs_val;
  logic [7:0]    rt_val;
  logic [7:0]    add_sum;
  logic [7:0]    imm_sext;
  logic [7:0]    mem_addr;
  logic [7:0]    jmp_target;
  logic [AW-1:0] mem_idx;
  logic [7:0]    load_val;

  // Operands and address arithmetic for the latched instruction; the address
  // wraps at 8 bits before its low bits select the memory word, and pc has
  // already been advanced past the instruction when the jump target is formed.
  always_comb begin
    rs_val     = regs[ir[5:4]];
    rt_val     = regs[ir[3:2]];
    add_sum    = rs_val + rt_val;
    imm_sext   = {{6{ir[1]}}, ir[1:0]};
    mem_addr   = rs_val + imm_sext;
    mem_idx    = mem_addr[AW-1:0];
    load_val   = dmem[mem_idx];
    jmp_target = pc + {{2{ir[5]}}, ir[5:0]};
  end

  // Control FSM with datapath updates; results land on the edge that ends EXEC
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= FETCH;
      pc        <= 8'd0;
      ir        <= 8'd0;
      halted_q  <= 1'b0;
      rw_en_q   <= 1'b0;
      rw_data_q <= 8'd0;
      rw_idx_q  <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 8'd0;
      end
      for (int i = 0; i < DMEM_DEPTH; i++) begin
        dmem[i] <= 8'(i);
      end
    end else begin
      rw_en_q <= 1'b0;
      case (state)
        FETCH: begin
          ir    <= bus.instruction;
          pc    <= pc + 8'd1;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          case (ir[7:6])
            2'b00: begin
              regs[ir[1:0]] <= add_sum;
              rw_en_q       <= 1'b1;
              rw_data_q     <= add_sum;
              rw_idx_q      <= ir[1:0];
            end
            2'b01: begin
              regs[ir[3:2]] <= load_val;
              rw_en_q       <= 1'b1;
              rw_data_q     <= load_val;
              rw_idx_q      <= ir[3:2];
            end
            2'b10: begin
              dmem[mem_idx] <= rt_val;
            end
            default: begin
              if (ir == HALT_WORD) begin
                state    <= HALT;
                halted_q <= 1'b1;
              end else begin
                pc <= jmp_target;
              end
            end
          endcase
        end
        default: begin
          state    <= HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.address  = pc;
  assign bus.halted   = halted_q;
  assign bus.rw_en    = rw_en_q;
  assign bus.rw_data  = rw_data_q;
  assign bus.rw_idx   = rw_idx_q;
  assign bus.dbg_data = regs[bus.dbg_sel];
endmodule

// File: tb/tb_sc_cpu_core.sv
// tb/tb_sc_cpu_core.sv - self-checking bench for sc_cpu_core with ISA-level reference model
module tb_sc_cpu_core;
  logic       clk;
  logic       clear;
  logic [1:0] dbg_sel;
  logic [7:0] rom [256];
  int         checks;
  int         errors;

  // instruction-level reference model state
  int m_reg [4];
  int m_mem [32];
  int m_pc;
  int m_halted;
  int m_wr;
  int m_last_data;
  int m_last_idx;

  sc_cpu_core_if bus ();

  assign bus.instruction = rom[bus.address];
  assign bus.dbg_sel     = dbg_sel;

  sc_cpu_core #(.DMEM_DEPTH(32), .HALT_WORD(8'hC3)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 256; i++) rom[i] = v;
  endtask

  task automatic start_run;
    clear = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic read_reg(input int k, output logic [7:0] v);
    dbg_sel = 2'(k);
    #1;
    v = bus.dbg_data;
  endtask

  function automatic int sx(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    for (int i = 0; i < 32; i++) m_mem[i] = i;
    m_pc = 0; m_halted = 0; m_last_data = 0; m_last_idx = 0; m_wr = 0;
  endtask

  // executes one whole instruction from the spec's rules
  task automatic model_step;
    int ins, op, rs, rt, imm, nxt, a;
    m_wr = 0;
    if (m_halted != 0) return;
    ins = int'(rom[m_pc]);
    op  = ins / 64;
    rs  = (ins / 16) % 4;
    rt  = (ins / 4) % 4;
    imm = ins % 4;
    nxt = (m_pc + 1) % 256;
    a   = ((m_reg[rs] + sx(imm, 2) + 256) % 256) % 32;
    m_pc = nxt;
    if (op == 0) begin
      m_reg[imm] = (m_reg[rs] + m_reg[rt]) % 256;
      m_wr = 1; m_last_data = m_reg[imm]; m_last_idx = imm;
    end else if (op == 1) begin
      m_reg[rt] = m_mem[a];
      m_wr = 1; m_last_data = m_reg[rt]; m_last_idx = rt;
    end else if (op == 2) begin
      m_mem[a] = m_reg[rt];
    end else if (ins == 8'hC3) begin
      m_halted = 1;
    end else begin
      m_pc = (nxt + sx(ins % 64, 6) + 256) % 256;
    end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    fill_rom(8'hC3);
    clear = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.address !== 8'd0) begin errors++; $display("FAIL reset_address got %0d exp 0", bus.address); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b exp 0", bus.halted); end
    checks++; if (bus.rw_en !== 1'b0) begin errors++; $display("FAIL reset_rw_en got %0b exp 0", bus.rw_en); end
    checks++; if (bus.rw_data !== 8'd0 || bus.rw_idx !== 2'd0) begin errors++; $display("FAIL reset_rw got data %0d idx %0d exp 0 0", bus.rw_data, bus.rw_idx); end
    for (int k = 0; k < 4; k++) begin
      read_reg(k, v);
      checks++; if (v !== 8'd0) begin errors++; $display("FAIL reset_reg%0d got %0d exp 0", k, v); end
    end
    for (int i = 0; i < 32; i++) begin
      checks++; if (dut.dmem[i] !== 8'(i)) begin errors++; $display("FAIL reset_dmem%0d got %0d exp %0d", i, dut.dmem[i], i); end
    end
  endtask

  task automatic test_program;
    logic [7:0] prog [11] = '{8'h41, 8'h45, 8'h06, 8'h1B, 8'h0C, 8'h0C, 8'h0D, 8'hB3, 8'h73, 8'h1E, 8'hC3};
    logic [7:0] exp_rw [9] = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd11, 8'd16, 8'd11, 8'd21};
    logic [7:0] exp_reg [4] = '{8'd11, 8'd16, 8'd21, 8'd5};
    logic [7:0] got [$];
    logic [7:0] v;
    int cycles;
    fill_rom(8'hC3);
    for (int i = 0; i < 11; i++) rom[i] = prog[i];
    start_run();
    cycles = 0;
    while (bus.halted !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
      if (bus.rw_en === 1'b1) got.push_back(bus.rw_data);
    end
    checks++; if (cycles != 22) begin errors++; $display("FAIL prog_halt_cycles got %0d exp 22", cycles); end
    checks++; if (got.size() != 9) begin errors++; $display("FAIL prog_rw_count got %0d exp 9", got.size()); end
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_rw[i]) begin errors++; $display("FAIL prog_rw%0d got %0d exp %0d", i, got[i], exp_rw[i]); end
    end
    for (int k = 0; k < 4; k++) begin
      read_reg(k, v);
      checks++; if (v !== exp_reg[k]) begin errors++; $display("FAIL prog_reg%0d got %0d exp %0d", k, v, exp_reg[k]); end
    end
    checks++; if (dut.dmem[4] !== 8'd11) begin errors++; $display("FAIL prog_dmem4 got %0d exp 11", dut.dmem[4]); end
    repeat (4) tick();
    checks++; if (bus.address !== 8'd11 || bus.halted !== 1'b1 || bus.rw_en !== 1'b0) begin
      errors++; $display("FAIL prog_halt_hold got addr %0d halted %0b rw_en %0b exp 11 1 0", bus.address, bus.halted, bus.rw_en);
    end
  endtask

  task automatic test_add_overflow;
    logic [7:0] prog [12] = '{8'h41, 8'h01, 8'h11, 8'h15, 8'h15, 8'h15, 8'h11, 8'h15, 8'h15, 8'h14, 8'h06, 8'hC3};
    logic [7:0] v;
    int pulses, run, maxrun, cycles;
    fill_rom(8'hC3);
    for (int i = 0; i < 12; i++) rom[i] = prog[i];
    start_run();
    pulses = 0; run = 0; maxrun = 0; cycles = 0;
    while (bus.halted !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
      if (bus.rw_en === 1'b1) begin
        pulses++; run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end
    checks++; if (pulses != 11 || maxrun != 1) begin errors++; $display("FAIL ovf_pulses got %0d maxrun %0d exp 11 1", pulses, maxrun); end
    checks++; if (bus.rw_data !== 8'd44 || bus.rw_idx !== 2'd2) begin errors++; $display("FAIL ovf_rw got %0d idx %0d exp 44 2", bus.rw_data, bus.rw_idx); end
    read_reg(0, v);
    checks++; if (v !== 8'd200) begin errors++; $display("FAIL ovf_s0 got %0d exp 200", v); end
    read_reg(1, v);
    checks++; if (v !== 8'd100) begin errors++; $display("FAIL ovf_s1 got %0d exp 100", v); end
    read_reg(2, v);
    checks++; if (v !== 8'd44) begin errors++; $display("FAIL ovf_s2 got %0d exp 44", v); end
  endtask

  task automatic test_negative_offset;
    logic [7:0] prog [8] = '{8'h47, 8'h41, 8'h01, 8'h11, 8'h16, 8'hA2, 8'h6E, 8'hC3};
    logic [7:0] v;
    int cycles, seen;
    fill_rom(8'hC3);
    for (int i = 0; i < 8; i++) rom[i] = prog[i];
    start_run();
    cycles = 0; seen = 0;
    while (bus.halted !== 1'b1 && cycles < 100) begin
      tick();
      cycles++;
      if (bus.rw_en === 1'b1 && seen == 0) begin
        seen = 1;
        checks++; if (bus.rw_data !== 8'd31 || bus.rw_idx !== 2'd1) begin errors++; $display("FAIL neg_lw got %0d idx %0d exp 31 1", bus.rw_data, bus.rw_idx); end
      end
    end
    checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL neg_timeout got halted %0b exp 1", bus.halted); end
    checks++; if (dut.dmem[4] !== 8'd1) begin errors++; $display("FAIL neg_sw_dmem4 got %0d exp 1", dut.dmem[4]); end
    checks++; if (dut.dmem[31] !== 8'd31 || dut.dmem[5] !== 8'd5) begin errors++; $display("FAIL neg_untouched got %0d %0d exp 31 5", dut.dmem[31], dut.dmem[5]); end
    read_reg(3, v);
    checks++; if (v !== 8'd1) begin errors++; $display("FAIL neg_reload got %0d exp 1", v); end
  endtask

  task automatic test_jmp;
    fill_rom(8'h00);
    rom[5] = 8'hC2;
    rom[8] = 8'hFF;
    start_run();
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 12 || c == 14 || c == 16 || c == 18) begin
        checks++; if (bus.address !== 8'd8) begin errors++; $display("FAIL jmp_c%0d got %0d exp 8", c, bus.address); end
      end
      if (c == 13) begin
        checks++; if (bus.address !== 8'd9) begin errors++; $display("FAIL jmp_fetch got %0d exp 9", bus.address); end
      end
    end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL jmp_halted got %0b exp 0", bus.halted); end
  endtask

  task automatic test_pc_wrap;
    fill_rom(8'h00);
    rom[0] = 8'hFE;
    start_run();
    tick(); tick();
    checks++; if (bus.address !== 8'd255) begin errors++; $display("FAIL wrap_target got %0d exp 255", bus.address); end
    tick();
    checks++; if (bus.address !== 8'd0) begin errors++; $display("FAIL wrap_incr got %0d exp 0", bus.address); end
    tick();
    checks++; if (bus.address !== 8'd0 || bus.rw_en !== 1'b1) begin errors++; $display("FAIL wrap_exec got addr %0d rw_en %0b exp 0 1", bus.address, bus.rw_en); end
  endtask

  task automatic test_clear_mid_exec;
    logic [7:0] v;
    int cycles;
    fill_rom(8'hC3);
    rom[0] = 8'h41;
    rom[1] = 8'h81;
    start_run();
    tick(); tick(); tick();
    checks++; if (bus.address !== 8'd2) begin errors++; $display("FAIL clr_pre got %0d exp 2", bus.address); end
    clear = 1'b1;
    #1;
    checks++; if (bus.address !== 8'd0) begin errors++; $display("FAIL clr_async got %0d exp 0", bus.address); end
    tick();
    checks++; if (dut.dmem[2] !== 8'd2) begin errors++; $display("FAIL clr_dmem2 got %0d exp 2", dut.dmem[2]); end
    read_reg(0, v);
    checks++; if (v !== 8'd0) begin errors++; $display("FAIL clr_s0 got %0d exp 0", v); end
    clear = 1'b0;
    tick();
    checks++; if (bus.address !== 8'd1) begin errors++; $display("FAIL clr_restart got %0d exp 1", bus.address); end
    cycles = 0;
    while (bus.halted !== 1'b1 && cycles < 50) begin
      tick();
      cycles++;
    end
    checks++; if (bus.halted !== 1'b1 || dut.dmem[2] !== 8'd1) begin errors++; $display("FAIL clr_rerun got halted %0b dmem2 %0d exp 1 1", bus.halted, dut.dmem[2]); end
  endtask

  task automatic test_random;
    logic [7:0] v;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom_range(0, 255));
      model_reset();
      start_run();
      for (int s = 0; s < 40; s++) begin
        model_step();
        tick();
        checks++; if (bus.rw_en !== 1'b0) begin errors++; $display("FAIL rnd%0d_s%0d_fetch_rw_en got %0b exp 0", r, s, bus.rw_en); end
        tick();
        checks++; if (bus.address !== 8'(m_pc)) begin errors++; $display("FAIL rnd%0d_s%0d_pc got %0d exp %0d", r, s, bus.address, m_pc); end
        checks++; if (bus.halted !== 1'(m_halted)) begin errors++; $display("FAIL rnd%0d_s%0d_halted got %0b exp %0d", r, s, bus.halted, m_halted); end
        checks++; if (bus.rw_en !== 1'(m_wr)) begin errors++; $display("FAIL rnd%0d_s%0d_rw_en got %0b exp %0d", r, s, bus.rw_en, m_wr); end
        checks++; if (bus.rw_data !== 8'(m_last_data) || bus.rw_idx !== 2'(m_last_idx)) begin
          errors++; $display("FAIL rnd%0d_s%0d_rw got %0d idx %0d exp %0d idx %0d", r, s, bus.rw_data, bus.rw_idx, m_last_data, m_last_idx);
        end
      end
      for (int k = 0; k < 4; k++) begin
        read_reg(k, v);
        checks++; if (v !== 8'(m_reg[k])) begin errors++; $display("FAIL rnd%0d_reg%0d got %0d exp %0d", r, k, v, m_reg[k]); end
      end
      for (int i = 0; i < 32; i++) begin
        checks++; if (dut.dmem[i] !== 8'(m_mem[i])) begin errors++; $display("FAIL rnd%0d_dmem%0d got %0d exp %0d", r, i, dut.dmem[i], m_mem[i]); end
      end
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    clear   = 1'b1;
    dbg_sel = 2'd0;
    test_reset();
    test_program();
    test_add_overflow();
    test_negative_offset();
    test_jmp();
    test_pc_wrap();
    test_clear_mid_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
